// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode encodings, FSM state type and constants for the
// iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [XLEN_DEF-1:0] XLEN_MIN = 32'h8000_0000;
  localparam logic [XLEN_DEF-1:0] ALL_ONES = 32'hFFFF_FFFF;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division step. Shifts the next
// dividend bit into the partial remainder and subtracts the divisor when it fits.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic [XLEN:0] sel;
  logic          unused_sel_msb;

  // trial subtract; the kept remainder is always below the divisor so its MSB is zero
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = (shifted >= {1'b0, divisor_i});
    sel     = q_o ? diff : shifted;
    rem_o   = sel[XLEN-1:0];
  end

  assign unused_sel_msb = sel[XLEN];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply,
// restoring divide, one bit per cycle). Divide-by-zero and signed overflow
// finish on a fast path. Define MULDIV_FAST_MUL_EN to compute all multiplies
// with a single-cycle 33x33 signed product instead of iterating.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [RD_W-1:0] rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            regwrite_out
);

  localparam int CW = $clog2(XLEN + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // {hi, lo}: product accumulator / multiplier for MUL*, {remainder, quotient} for DIV*
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;      // negate product / quotient at the end
  logic              negr_q, negr_d;    // negate remainder at the end
  logic              fast_q, fast_d;    // acc_q low word already holds the answer
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              wr_q, wr_d;

  // operand decode at accept time
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic            fast_hit;
  logic [XLEN-1:0] fast_val;

  assign a_neg    = a_is_signed(funct3) & rs1_val[XLEN-1];
  assign b_neg    = b_is_signed(funct3) & rs2_val[XLEN-1];
  assign a_mag    = a_neg ? -rs1_val : rs1_val;
  assign b_mag    = b_neg ? -rs2_val : rs2_val;
  assign div_zero = funct3[2] && (rs2_val == '0);
  assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (rs1_val == XLEN_MIN) && (rs2_val == ALL_ONES);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fm_p;
  logic [1:0]               unused_fm_top;
  assign fm_a          = {a_is_signed(funct3) & rs1_val[XLEN-1], rs1_val};
  assign fm_b          = {b_is_signed(funct3) & rs2_val[XLEN-1], rs2_val};
  assign fm_p          = fm_a * fm_b;
  assign unused_fm_top = fm_p[2*XLEN+1:2*XLEN];
`endif

  // pick the cases that bypass the iterative datapath
  always_comb begin
    fast_hit = 1'b0;
    fast_val = '0;
    if (div_zero) begin
      fast_hit = 1'b1;
      fast_val = funct3[1] ? rs1_val : ALL_ONES;
    end else if (div_ovf) begin
      fast_hit = 1'b1;
      fast_val = funct3[1] ? '0 : XLEN_MIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!funct3[2]) begin
      fast_hit = 1'b1;
      fast_val = (funct3 == F3_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
`endif
  end

  // one iteration of each algorithm from the shared accumulator
  logic [XLEN-1:0]   ds_rem;
  logic              ds_q;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next;

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .bit_i     (acc_q[XLEN-1]),
    .divisor_i (opb_q),
    .rem_o     (ds_rem),
    .q_o       (ds_q)
  );

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_next = {ds_rem, acc_q[XLEN-2:0], ds_q};

  // sign correction and word select once iteration is finished
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quo_fix  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // result mux for the DONE cycle
  always_comb begin
    final_val = '0;
    if (fast_q) begin
      final_val = acc_q[XLEN-1:0];
    end else begin
      case (op_q)
        F3_MUL:                      final_val = prod_fix[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod_fix[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:             final_val = quo_fix;
        default:                     final_val = rem_fix;
      endcase
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    fast_d   = fast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_d     = rd_q;
    wr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          op_d   = funct3;
          rd_d   = rd_in;
          opb_d  = b_mag;
          neg_d  = a_neg ^ b_neg;
          negr_d = a_neg;
          if (fast_hit) begin
            acc_d   = {{XLEN{1'b0}}, fast_val};
            fast_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            fast_d  = 1'b0;
            cnt_d   = CW'(XLEN);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = final_val;
        wr_d     = (rd_q != '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      fast_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      fast_q   <= fast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign rd_out       = rd_q;
  assign regwrite_out = wr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven scoreboard bench for muldiv_unit, plus
// hand-written sequences for ignored start, rd=0 and reset mid-operation.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [RD_W-1:0] rd_in;
  logic            busy, done;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;
  logic            regwrite_out;

  muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .funct3       (funct3),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .rd_in        (rd_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .rd_out       (rd_out),
    .regwrite_out (regwrite_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] res;
    int              lat;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [RD_W-1:0] rd;
    logic            wr;
    int              lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // drive one request, accepted at the next rising edge; queue its expectation
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RD_W-1:0] rd, input logic [XLEN-1:0] res, input int lat);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = res;
    e.rd  = rd;
    e.wr  = (rd != '0);
    e.lat = lat;
    sbq.push_back(e);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  // wait (bounded) for done, compare against the scoreboard head; optionally
  // pulse a stray start request at cycle pulse_at of the operation
  task automatic retire(input int pulse_at);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      if (n == pulse_at) begin
        start   = 1'b1;
        funct3  = F3_MULHU;
        rs1_val = 32'h0000_1111;
        rs2_val = 32'h0000_0003;
        rd_in   = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
      return;
    end
    if (sbq.size() == 0) begin
      check("unexpected_done", 64'd1, 64'd0);
      return;
    end
    e = sbq.pop_front();
    check("result", {32'd0, result}, {32'd0, e.res});
    check("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
    check("regwrite", {63'd0, regwrite_out}, {63'd0, e.wr});
    check("latency", 64'(n), 64'(e.lat));
    check("busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("result_held", {32'd0, result}, {32'd0, e.res});
  endtask

  vec_t vt[22];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int extra;

    vt[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, MUL_LAT};
    vt[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, MUL_LAT};
    vt[2]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, MUL_LAT};
    vt[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'hFFFF_FFFF, MUL_LAT};
    vt[4]  = '{F3_MUL,    32'h8000_0000, 32'h8000_0000, 5'd8,  32'h0000_0000, MUL_LAT};
    vt[5]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, MUL_LAT};
    vt[6]  = '{F3_MUL,    32'h0001_0003, 32'h0002_0005, 5'd10, 32'h000B_000F, MUL_LAT};
    vt[7]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, DIV_LAT};
    vt[8]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, DIV_LAT};
    vt[9]  = '{F3_DIVU,   32'd100,       32'd7,         5'd13, 32'd14,        DIV_LAT};
    vt[10] = '{F3_REMU,   32'd100,       32'd7,         5'd14, 32'd2,         DIV_LAT};
    vt[11] = '{F3_DIV,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd15, 32'd6,         DIV_LAT};
    vt[12] = '{F3_REM,    32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd16, 32'hFFFF_FFFE, DIV_LAT};
    vt[13] = '{F3_DIV,    32'd20,        32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFFA, DIV_LAT};
    vt[14] = '{F3_REM,    32'd20,        32'hFFFF_FFFD, 5'd18, 32'd2,         DIV_LAT};
    vt[15] = '{F3_DIVU,   32'd5,         32'd0,         5'd19, 32'hFFFF_FFFF, FAST_LAT};
    vt[16] = '{F3_REMU,   32'd5,         32'd0,         5'd20, 32'd5,         FAST_LAT};
    vt[17] = '{F3_DIV,    32'd7,         32'd0,         5'd21, 32'hFFFF_FFFF, FAST_LAT};
    vt[18] = '{F3_REM,    32'd7,         32'd0,         5'd22, 32'd7,         FAST_LAT};
    vt[19] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h8000_0000, FAST_LAT};
    vt[20] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'd0,         FAST_LAT};
    vt[21] = '{F3_MULHU,  32'h8000_0000, 32'd4,         5'd0,  32'd2,         MUL_LAT};

    // reset state
    reset   = 1'b0;
    start   = 1'b0;
    funct3  = '0;
    rs1_val = '0;
    rs2_val = '0;
    rd_in   = '0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_rd_out", {59'd0, rd_out}, 64'd0);
    check("rst_regwrite", {63'd0, regwrite_out}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // table: every op, signs, fast paths, rd=0
    for (int i = 0; i < 22; i++) begin
      issue(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, vt[i].res, vt[i].lat);
      retire(-1);
    end

    // stray start at cycle 10 of a DIV: ignored, single done pulse, no queued op
    issue(F3_DIV, 32'hFFFF_FF9C, 32'd9, 5'd2, 32'hFFFF_FFF5, DIV_LAT);
    retire(10);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    check("no_extra_done", 64'(extra), 64'd0);

    // reset in the middle of a DIVU aborts it
    issue(F3_DIVU, 32'hDEAD_BEEF, 32'h0000_0013, 5'd4, 32'd0, DIV_LAT);
    repeat (14) @(posedge clk);
    #2;
    check("busy_mid_run", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_regwrite", {63'd0, regwrite_out}, 64'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    check("no_done_after_abort", 64'(extra), 64'd0);

    issue(F3_MUL, 32'd3, 32'd4, 5'd1, 32'd12, MUL_LAT);
    retire(-1);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
